// File: rtl/regfile_2w2r_if.sv
// Decode/writeback bundle for the 2-write 2-read register file.
// Reads are zero-latency, writes commit next edge; no backpressure.
interface regfile_2w2r_if #(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 4
);
    logic [ADDR_W-1:0] ra_addr;
    logic [ADDR_W-1:0] rb_addr;
    logic [DATA_W-1:0] ra_data;
    logic [DATA_W-1:0] rb_data;
    logic              ra_busy;
    logic              rb_busy;
    logic              we0;
    logic [ADDR_W-1:0] wa0;
    logic [DATA_W-1:0] wd0;
    logic              we1;
    logic [ADDR_W-1:0] wa1;
    logic [DATA_W-1:0] wd1;
    logic              bset;
    logic [ADDR_W-1:0] bset_addr;
    logic              wconflict;

    modport master (
        output ra_addr, rb_addr, we0, wa0, wd0, we1, wa1, wd1, bset, bset_addr,
        input  ra_data, rb_data, ra_busy, rb_busy, wconflict
    );

    modport slave (
        input  ra_addr, rb_addr, we0, wa0, wd0, we1, wa1, wd1, bset, bset_addr,
        output ra_data, rb_data, ra_busy, rb_busy, wconflict
    );
endinterface

// File: rtl/regfile_2w2r.sv
// Register file, 2 combinational reads / 2 writes, busy scoreboard, R0 = 0.
// Reads 0 cycles, writes/busy commit at edge, wconflict 1 cycle; never stalls.
module regfile_2w2r #(
    parameter int DATA_W   = 32,
    parameter int NUM_REGS = 16,
    parameter int ADDR_W   = 4,
    parameter int BYPASS   = 1
) (
    input  logic           clk,
    input  logic           rst,
    regfile_2w2r_if.slave  rf
);
    logic [DATA_W-1:0]   regs [NUM_REGS];
    logic [NUM_REGS-1:0] busy;
    logic [NUM_REGS-1:0] busy_nxt;
    logic                wconflict_q;

    logic w0_hit, w1_hit, bset_hit;
    logic a_m0, a_m1, b_m0, b_m1;
    logic a_bset, b_bset;

    assign w0_hit   = rf.we0 && (rf.wa0 != '0);
    assign w1_hit   = rf.we1 && (rf.wa1 != '0);
    assign bset_hit = rf.bset && (rf.bset_addr != '0);

    assign a_m0   = (BYPASS != 0) && w0_hit && (rf.wa0 == rf.ra_addr);
    assign a_m1   = (BYPASS != 0) && w1_hit && (rf.wa1 == rf.ra_addr);
    assign b_m0   = (BYPASS != 0) && w0_hit && (rf.wa0 == rf.rb_addr);
    assign b_m1   = (BYPASS != 0) && w1_hit && (rf.wa1 == rf.rb_addr);
    assign a_bset = bset_hit && (rf.bset_addr == rf.ra_addr);
    assign b_bset = bset_hit && (rf.bset_addr == rf.rb_addr);

    // Set is applied after the clears so a newly issued producer wins.
    always_comb begin
        busy_nxt = busy;
        if (w0_hit)   busy_nxt[rf.wa0]       = 1'b0;
        if (w1_hit)   busy_nxt[rf.wa1]       = 1'b0;
        if (bset_hit) busy_nxt[rf.bset_addr] = 1'b1;
        busy_nxt[0] = 1'b0;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < NUM_REGS; i++) regs[i] <= '0;
            busy        <= '0;
            wconflict_q <= 1'b0;
        end else begin
            // Port 0 is written last so it wins a same-address collision.
            if (w1_hit) regs[rf.wa1] <= rf.wd1;
            if (w0_hit) regs[rf.wa0] <= rf.wd0;
            busy        <= busy_nxt;
            wconflict_q <= w0_hit && w1_hit && (rf.wa0 == rf.wa1);
        end
    end

    always_comb begin
        rf.ra_data = regs[rf.ra_addr];
        if (a_m0)      rf.ra_data = rf.wd0;
        else if (a_m1) rf.ra_data = rf.wd1;
        if (rf.ra_addr == '0) rf.ra_data = '0;

        rf.rb_data = regs[rf.rb_addr];
        if (b_m0)      rf.rb_data = rf.wd0;
        else if (b_m1) rf.rb_data = rf.wd1;
        if (rf.rb_addr == '0) rf.rb_data = '0;
    end

    // A forwarded read hides the stored busy bit unless that register is being re-issued.
    assign rf.ra_busy   = busy[rf.ra_addr] && !((a_m0 || a_m1) && !a_bset);
    assign rf.rb_busy   = busy[rf.rb_addr] && !((b_m0 || b_m1) && !b_bset);
    assign rf.wconflict = wconflict_q;
endmodule

// File: tb/tb_regfile_2w2r.sv
module tb_regfile_2w2r;
    logic clk = 1'b0;
    logic rst = 1'b1;
    int   errors = 0;
    int   checks = 0;

    always #5 clk = ~clk;

    regfile_2w2r_if #(.DATA_W(32), .ADDR_W(4)) bi ();
    regfile_2w2r_if #(.DATA_W(32), .ADDR_W(4)) bo ();

    // Bypass-less instance sees the same stimulus.
    assign bo.ra_addr   = bi.ra_addr;
    assign bo.rb_addr   = bi.rb_addr;
    assign bo.we0       = bi.we0;
    assign bo.wa0       = bi.wa0;
    assign bo.wd0       = bi.wd0;
    assign bo.we1       = bi.we1;
    assign bo.wa1       = bi.wa1;
    assign bo.wd1       = bi.wd1;
    assign bo.bset      = bi.bset;
    assign bo.bset_addr = bi.bset_addr;

    regfile_2w2r #(.DATA_W(32), .NUM_REGS(16), .ADDR_W(4), .BYPASS(1)) dut_byp (
        .clk(clk), .rst(rst), .rf(bi));
    regfile_2w2r #(.DATA_W(32), .NUM_REGS(16), .ADDR_W(4), .BYPASS(0)) dut_nob (
        .clk(clk), .rst(rst), .rf(bo));

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        bi.we0 = 0; bi.wa0 = '0; bi.wd0 = '0;
        bi.we1 = 0; bi.wa1 = '0; bi.wd1 = '0;
        bi.bset = 0; bi.bset_addr = '0;
        bi.ra_addr = '0; bi.rb_addr = '0;
    endtask

    task automatic test_reset();
        rst = 1; idle();
        tick(); tick();
        rst = 0;
        for (int i = 0; i < 16; i++) begin
            bi.ra_addr = 4'(i); bi.rb_addr = 4'(15 - i);
            #1;
            checks++;
            if (bi.ra_data !== 32'h0) begin
                errors++; $display("FAIL reset_ra r%0d: got %h want 0", i, bi.ra_data);
            end
            checks++;
            if (bi.rb_data !== 32'h0) begin
                errors++; $display("FAIL reset_rb r%0d: got %h want 0", 15 - i, bi.rb_data);
            end
            checks++;
            if (bi.ra_busy !== 1'b0) begin
                errors++; $display("FAIL reset_busy r%0d: got %b want 0", i, bi.ra_busy);
            end
        end
        checks++;
        if (bi.wconflict !== 1'b0) begin
            errors++; $display("FAIL reset_wconflict: got %b want 0", bi.wconflict);
        end
        idle();
        bi.we0 = 1; bi.wa0 = 4'd3; bi.wd0 = 32'hDEADBEEF;
        tick();
        idle(); bi.ra_addr = 4'd3; #1;
        checks++;
        if (bi.ra_data !== 32'hDEADBEEF) begin
            errors++; $display("FAIL write_r3: got %h want deadbeef", bi.ra_data);
        end
        checks++;
        if (bo.ra_data !== 32'hDEADBEEF) begin
            errors++; $display("FAIL write_r3_nob: got %h want deadbeef", bo.ra_data);
        end
    endtask

    task automatic test_r0();
        idle();
        bi.we0 = 1; bi.wa0 = 4'd0; bi.wd0 = 32'h1234;
        bi.we1 = 1; bi.wa1 = 4'd0; bi.wd1 = 32'h1234;
        bi.bset = 1; bi.bset_addr = 4'd0;
        #1;
        checks++;
        if (bi.ra_data !== 32'h0) begin
            errors++; $display("FAIL r0_bypass: got %h want 0", bi.ra_data);
        end
        tick();
        idle(); #1;
        checks++;
        if (bi.ra_data !== 32'h0) begin
            errors++; $display("FAIL r0_read: got %h want 0", bi.ra_data);
        end
        checks++;
        if (bi.ra_busy !== 1'b0) begin
            errors++; $display("FAIL r0_busy: got %b want 0", bi.ra_busy);
        end
        checks++;
        if (bi.wconflict !== 1'b0) begin
            errors++; $display("FAIL r0_wconflict: got %b want 0", bi.wconflict);
        end
    endtask

    task automatic test_conflict();
        idle();
        bi.we0 = 1; bi.wa0 = 4'd5; bi.wd0 = 32'h11;
        bi.we1 = 1; bi.wa1 = 4'd5; bi.wd1 = 32'h22;
        bi.ra_addr = 4'd5;
        #1;
        checks++;
        if (bi.ra_data !== 32'h11) begin
            errors++; $display("FAIL conflict_bypass: got %h want 11", bi.ra_data);
        end
        tick();
        idle(); bi.ra_addr = 4'd5; #1;
        checks++;
        if (bi.ra_data !== 32'h11) begin
            errors++; $display("FAIL conflict_data: got %h want 11", bi.ra_data);
        end
        checks++;
        if (bi.wconflict !== 1'b1) begin
            errors++; $display("FAIL conflict_flag: got %b want 1", bi.wconflict);
        end
        tick();
        checks++;
        if (bi.wconflict !== 1'b0) begin
            errors++; $display("FAIL conflict_clear: got %b want 0", bi.wconflict);
        end
    endtask

    task automatic test_dual_write();
        idle();
        bi.we0 = 1; bi.wa0 = 4'd7; bi.wd0 = 32'h55;
        tick();
        idle();
        bi.we0 = 1; bi.wa0 = 4'd2; bi.wd0 = 32'hA;
        bi.we1 = 1; bi.wa1 = 4'd7; bi.wd1 = 32'hB;
        bi.ra_addr = 4'd7; bi.rb_addr = 4'd2;
        #1;
        checks++;
        if (bi.ra_data !== 32'hB) begin
            errors++; $display("FAIL dual_bypass_r7: got %h want b", bi.ra_data);
        end
        checks++;
        if (bi.rb_data !== 32'hA) begin
            errors++; $display("FAIL dual_bypass_r2: got %h want a", bi.rb_data);
        end
        checks++;
        if (bo.ra_data !== 32'h55) begin
            errors++; $display("FAIL dual_nobypass_r7: got %h want 55", bo.ra_data);
        end
        checks++;
        if (bo.rb_data !== 32'h0) begin
            errors++; $display("FAIL dual_nobypass_r2: got %h want 0", bo.rb_data);
        end
        checks++;
        if (bi.wconflict !== 1'b0) begin
            errors++; $display("FAIL dual_wconflict: got %b want 0", bi.wconflict);
        end
        tick();
        idle(); bi.ra_addr = 4'd7; bi.rb_addr = 4'd2; #1;
        checks++;
        if (bo.ra_data !== 32'hB) begin
            errors++; $display("FAIL dual_stored_r7: got %h want b", bo.ra_data);
        end
        checks++;
        if (bo.rb_data !== 32'hA) begin
            errors++; $display("FAIL dual_stored_r2: got %h want a", bo.rb_data);
        end
        checks++;
        if (bi.wconflict !== 1'b0) begin
            errors++; $display("FAIL dual_no_conflict: got %b want 0", bi.wconflict);
        end
    endtask

    task automatic test_scoreboard();
        idle();
        bi.bset = 1; bi.bset_addr = 4'd4;
        tick();
        idle(); bi.ra_addr = 4'd4; bi.rb_addr = 4'd4; #1;
        checks++;
        if (bi.ra_busy !== 1'b1) begin
            errors++; $display("FAIL sb_set: got %b want 1", bi.ra_busy);
        end
        bi.we0 = 1; bi.wa0 = 4'd4; bi.wd0 = 32'h44;
        #1;
        checks++;
        if (bi.ra_busy !== 1'b0) begin
            errors++; $display("FAIL sb_fwd_busy: got %b want 0", bi.ra_busy);
        end
        checks++;
        if (bo.rb_busy !== 1'b1) begin
            errors++; $display("FAIL sb_nob_busy: got %b want 1", bo.rb_busy);
        end
        tick();
        idle(); bi.ra_addr = 4'd4; #1;
        checks++;
        if (bi.ra_busy !== 1'b0) begin
            errors++; $display("FAIL sb_cleared: got %b want 0", bi.ra_busy);
        end
        checks++;
        if (bi.ra_data !== 32'h44) begin
            errors++; $display("FAIL sb_data44: got %h want 44", bi.ra_data);
        end
        bi.bset = 1; bi.bset_addr = 4'd4;
        tick();
        idle();
        bi.bset = 1; bi.bset_addr = 4'd4;
        bi.we0 = 1; bi.wa0 = 4'd4; bi.wd0 = 32'h99;
        bi.ra_addr = 4'd4;
        #1;
        checks++;
        if (bi.ra_busy !== 1'b1) begin
            errors++; $display("FAIL sb_reissue_fwd_busy: got %b want 1", bi.ra_busy);
        end
        tick();
        idle(); bi.ra_addr = 4'd4; #1;
        checks++;
        if (bi.ra_busy !== 1'b1) begin
            errors++; $display("FAIL sb_set_wins: got %b want 1", bi.ra_busy);
        end
        checks++;
        if (bi.ra_data !== 32'h99) begin
            errors++; $display("FAIL sb_data99: got %h want 99", bi.ra_data);
        end
        bi.we1 = 1; bi.wa1 = 4'd4; bi.wd1 = 32'h77;
        tick();
        idle(); bi.ra_addr = 4'd4; #1;
        checks++;
        if (bo.ra_busy !== 1'b0) begin
            errors++; $display("FAIL sb_port1_clear: got %b want 0", bo.ra_busy);
        end
        checks++;
        if (bo.ra_data !== 32'h77) begin
            errors++; $display("FAIL sb_data77: got %h want 77", bo.ra_data);
        end
    endtask

    task automatic test_back_to_back();
        idle();
        bi.we0 = 1; bi.wa0 = 4'd6; bi.wd0 = 32'h1;
        bi.we1 = 1; bi.wa1 = 4'd6; bi.wd1 = 32'h2;
        tick();
        bi.wd0 = 32'h3; bi.wd1 = 32'h4;
        checks++;
        if (bi.wconflict !== 1'b1) begin
            errors++; $display("FAIL b2b_first: got %b want 1", bi.wconflict);
        end
        tick();
        idle(); bi.ra_addr = 4'd6; #1;
        checks++;
        if (bi.wconflict !== 1'b1) begin
            errors++; $display("FAIL b2b_second: got %b want 1", bi.wconflict);
        end
        checks++;
        if (bi.ra_data !== 32'h3) begin
            errors++; $display("FAIL b2b_data: got %h want 3", bi.ra_data);
        end
        tick();
        checks++;
        if (bi.wconflict !== 1'b0) begin
            errors++; $display("FAIL b2b_end: got %b want 0", bi.wconflict);
        end
    endtask

    task automatic test_mid_reset();
        idle();
        bi.we0 = 1; bi.wa0 = 4'd9; bi.wd0 = 32'h33;
        bi.bset = 1; bi.bset_addr = 4'd9;
        tick();
        idle();
        bi.we0 = 1; bi.wa0 = 4'd9; bi.wd0 = 32'hFF;
        bi.we1 = 1; bi.wa1 = 4'd9; bi.wd1 = 32'hEE;
        bi.bset = 1; bi.bset_addr = 4'd9;
        rst = 1;
        tick();
        rst = 0;
        idle(); bi.ra_addr = 4'd9; bi.rb_addr = 4'd3; #1;
        checks++;
        if (bo.ra_data !== 32'h0) begin
            errors++; $display("FAIL mid_rst_data: got %h want 0", bo.ra_data);
        end
        checks++;
        if (bo.ra_busy !== 1'b0) begin
            errors++; $display("FAIL mid_rst_busy: got %b want 0", bo.ra_busy);
        end
        checks++;
        if (bo.wconflict !== 1'b0) begin
            errors++; $display("FAIL mid_rst_wconflict: got %b want 0", bo.wconflict);
        end
        checks++;
        if (bo.rb_data !== 32'h0) begin
            errors++; $display("FAIL mid_rst_r3: got %h want 0", bo.rb_data);
        end
    endtask

    initial begin
        idle();
        test_reset();
        test_r0();
        test_conflict();
        test_dual_write();
        test_scoreboard();
        test_back_to_back();
        test_mid_reset();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
